// File: rtl/psg_bus_sequencer.sv
// Queues CPU PSG register accesses and replays them as YM2149 BDIR/BC1 bus cycles
// aligned to PSG_CEN, after an optional mute init sequence.
//   state   | meaning
//   IDLE    | waiting for an init-ROM op or a FIFO entry
//   SETUP   | data driven, BDIR/BC1=00, waiting for PSG_CEN
//   ACTIVE  | BDIR/BC1=op, held for HOLD_CEN PSG_CEN pulses
//   RECOVER | BDIR/BC1=00 until the next PSG_CEN pulse
module psg_bus_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CEN   = 2,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic       CLKSYS,
  input  logic       RESETBn,
  input  logic       PSG_CEN,
  input  logic [7:0] MDATABUS_in,
  input  logic       WR_DATA,
  input  logic       WR_CMD,
  output logic [7:0] cpu_rdata,
  output logic       busy,
  output logic       fifo_full,
  output logic       ovf,
  output logic       init_done,
  output logic       psg_bdir,
  output logic       psg_bc1,
  output logic [7:0] psg_data_o,
  input  logic [7:0] psg_data_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (HOLD_CEN > 1) ? $clog2(HOLD_CEN) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CEN - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACTIVE, S_RECOVER} state_t;

  state_t        state_q, state_d;
  logic [7:0]    dlat_q, dlat_d;
  logic [9:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] cen_cnt_q, cen_cnt_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    init_ptr_q, init_ptr_d;
  logic          init_done_q, init_done_d;
  logic [1:0]    bus_q, bus_d;
  logic [7:0]    pdata_q, pdata_d;

  logic       cmd_valid, full, empty, push, pop;
  logic       init_avail, fifo_avail, init_step, final_pulse;
  logic [9:0] rom_entry, fifo_head;

  assign cmd_valid   = WR_CMD & (MDATABUS_in[1:0] != 2'b00);
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign push        = cmd_valid & ~full;
  assign init_avail  = ~init_done_q & ~init_ptr_q[3];
  assign fifo_avail  = init_done_q & ~empty;
  assign init_step   = (state_q == S_IDLE) & init_avail;
  assign pop         = (state_q == S_IDLE) & fifo_avail;
  assign final_pulse = (state_q == S_ACTIVE) & PSG_CEN & (cen_cnt_q == HOLD_LAST);
  assign fifo_head   = fifo_mem_q[rd_ptr_q];

  // Mute sequence: enable register 0x07=0x3F, then zero the three amplitude registers.
  always_comb begin
    rom_entry = 10'h000;
    case (init_ptr_q[2:0])
      3'd0: rom_entry = {2'b11, 8'h07};
      3'd1: rom_entry = {2'b10, 8'h3F};
      3'd2: rom_entry = {2'b11, 8'h08};
      3'd3: rom_entry = {2'b10, 8'h00};
      3'd4: rom_entry = {2'b11, 8'h09};
      3'd5: rom_entry = {2'b10, 8'h00};
      3'd6: rom_entry = {2'b11, 8'h0A};
      default: rom_entry = {2'b10, 8'h00};
    endcase
  end

  // State register.
  always_ff @(posedge CLKSYS) begin
    if (!RESETBn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (init_avail | fifo_avail) state_d = S_SETUP;
      S_SETUP:   if (PSG_CEN) state_d = S_ACTIVE;
      S_ACTIVE:  if (final_pulse) state_d = S_RECOVER;
      S_RECOVER: if (PSG_CEN) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    dlat_d      = dlat_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    op_d        = op_q;
    data_d      = data_q;
    cen_cnt_d   = cen_cnt_q;
    rdata_d     = rdata_q;
    ovf_d       = ovf_q;
    init_ptr_d  = init_ptr_q;
    init_done_d = init_done_q;

    if (WR_DATA & ~WR_CMD) dlat_d = MDATABUS_in;
    if (cmd_valid & full)  ovf_d  = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (init_step) begin
      op_d       = rom_entry[9:8];
      data_d     = rom_entry[7:0];
      init_ptr_d = init_ptr_q + 4'd1;
    end else if (pop) begin
      op_d   = fifo_head[9:8];
      data_d = fifo_head[7:0];
    end
    if ((state_q == S_IDLE) & ~init_done_q & init_ptr_q[3]) init_done_d = 1'b1;

    if (state_q != S_ACTIVE) cen_cnt_d = '0;
    else if (final_pulse)    cen_cnt_d = '0;
    else if (PSG_CEN)        cen_cnt_d = cen_cnt_q + CW'(1);

    if (final_pulse & (op_q == 2'b01)) rdata_d = psg_data_i;
  end

  // Output logic: pin values for the coming state, registered below.
  always_comb begin
    bus_d   = 2'b00;
    pdata_d = data_d;
    if (state_d == S_ACTIVE) bus_d = op_d;
  end

  always_ff @(posedge CLKSYS) begin
    if (!RESETBn) begin
      dlat_q      <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      op_q        <= 2'b00;
      data_q      <= 8'h00;
      cen_cnt_q   <= '0;
      rdata_q     <= 8'hFF;
      ovf_q       <= 1'b0;
      init_ptr_q  <= 4'd0;
      init_done_q <= ~INIT_EN;
      bus_q       <= 2'b00;
      pdata_q     <= 8'h00;
    end else begin
      dlat_q      <= dlat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cen_cnt_q   <= cen_cnt_d;
      rdata_q     <= rdata_d;
      ovf_q       <= ovf_d;
      init_ptr_q  <= init_ptr_d;
      init_done_q <= init_done_d;
      bus_q       <= bus_d;
      pdata_q     <= pdata_d;
    end
  end

  // FIFO storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge CLKSYS) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {MDATABUS_in[1:0], dlat_q};
  end

  assign cpu_rdata  = rdata_q;
  assign busy       = ~empty | (state_q != S_IDLE) | ~init_done_q;
  assign fifo_full  = full;
  assign ovf        = ovf_q;
  assign init_done  = init_done_q;
  assign psg_bdir   = bus_q[1];
  assign psg_bc1    = bus_q[0];
  assign psg_data_o = pdata_q;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Directed bench for psg_bus_sequencer: bus-op monitor plus hand-computed expected op lists.
module tb_psg_bus_sequencer;

  localparam int HOLD = 2;

  logic       CLKSYS = 1'b0;
  logic       RESETBn = 1'b0;
  logic       PSG_CEN = 1'b0;
  logic [7:0] MDATABUS_in = 8'h00;
  logic       WR_DATA = 1'b0;
  logic       WR_CMD = 1'b0;
  logic [7:0] cpu_rdata;
  logic       busy, fifo_full, ovf, init_done, psg_bdir, psg_bc1;
  logic [7:0] psg_data_o;
  logic [7:0] psg_data_i = 8'h33;

  int n_chk = 0;
  int n_fail = 0;
  bit cen_en = 1'b0;

  logic [1:0] q_op[$];
  logic [7:0] q_dat[$];
  int         q_hold[$];
  logic [1:0] e_op[$];
  logic [7:0] e_dat[$];

  psg_bus_sequencer #(.FIFO_DEPTH(4), .HOLD_CEN(HOLD), .INIT_EN(1'b1)) dut (
    .CLKSYS(CLKSYS), .RESETBn(RESETBn), .PSG_CEN(PSG_CEN),
    .MDATABUS_in(MDATABUS_in), .WR_DATA(WR_DATA), .WR_CMD(WR_CMD),
    .cpu_rdata(cpu_rdata), .busy(busy), .fifo_full(fifo_full), .ovf(ovf),
    .init_done(init_done), .psg_bdir(psg_bdir), .psg_bc1(psg_bc1),
    .psg_data_o(psg_data_o), .psg_data_i(psg_data_i)
  );

  always #5 CLKSYS = ~CLKSYS;

  // PSG_CEN: one clock in eight while enabled.
  initial begin
    int div = 0;
    forever begin
      @(posedge CLKSYS); #1;
      div = (div + 1) % 8;
      PSG_CEN = cen_en && (div == 0);
    end
  end

  // Bus monitor: records each active phase and drives 0x5A only on its final pulse.
  initial begin
    bit act, prev;
    logic [1:0] cur_op;
    logic [7:0] cur_dat;
    int cur_hold;
    prev = 1'b0; cur_op = 2'b00; cur_dat = 8'h00; cur_hold = 0;
    forever begin
      @(negedge CLKSYS);
      act = (psg_bdir === 1'b1) || (psg_bc1 === 1'b1);
      psg_data_i = 8'h33;
      if (act) begin
        if (!prev) begin
          cur_op = {psg_bdir, psg_bc1}; cur_dat = psg_data_o; cur_hold = 0;
        end
        if (PSG_CEN === 1'b1) begin
          if (cur_hold == HOLD - 1) psg_data_i = 8'h5A;
          cur_hold++;
        end
      end else if (prev) begin
        q_op.push_back(cur_op); q_dat.push_back(cur_dat); q_hold.push_back(cur_hold);
      end
      prev = act;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_data(input logic [7:0] d);
    @(posedge CLKSYS); #1; MDATABUS_in = d; WR_DATA = 1'b1;
    @(posedge CLKSYS); #1; WR_DATA = 1'b0;
  endtask

  task automatic cpu_cmd(input logic [7:0] c);
    @(posedge CLKSYS); #1; MDATABUS_in = c; WR_CMD = 1'b1;
    @(posedge CLKSYS); #1; WR_CMD = 1'b0;
  endtask

  task automatic cpu_both(input logic [7:0] c);
    @(posedge CLKSYS); #1; MDATABUS_in = c; WR_CMD = 1'b1; WR_DATA = 1'b1;
    @(posedge CLKSYS); #1; WR_CMD = 1'b0; WR_DATA = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge CLKSYS);
    while (busy && n < 3000) begin @(negedge CLKSYS); n++; end
    chk(tag, busy, 1'b0);
  endtask

  task automatic exp_push(input logic [1:0] op, input logic [7:0] d);
    e_op.push_back(op); e_dat.push_back(d);
  endtask

  task automatic exp_rom();
    exp_push(2'b11, 8'h07); exp_push(2'b10, 8'h3F);
    exp_push(2'b11, 8'h08); exp_push(2'b10, 8'h00);
    exp_push(2'b11, 8'h09); exp_push(2'b10, 8'h00);
    exp_push(2'b11, 8'h0A); exp_push(2'b10, 8'h00);
  endtask

  task automatic verify_ops(input string tag);
    chk($sformatf("%s_count", tag), q_op.size(), e_op.size());
    for (int i = 0; i < e_op.size() && i < q_op.size(); i++) begin
      chk($sformatf("%s_op%0d", tag, i), q_op[i], e_op[i]);
      chk($sformatf("%s_dat%0d", tag, i), q_dat[i], e_dat[i]);
      chk($sformatf("%s_hold%0d", tag, i), q_hold[i], HOLD);
    end
    q_op.delete(); q_dat.delete(); q_hold.delete();
    e_op.delete(); e_dat.delete();
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(posedge CLKSYS);
    @(negedge CLKSYS);
    chk("rst_bdir", psg_bdir, 1'b0);
    chk("rst_bc1", psg_bc1, 1'b0);
    chk("rst_data", psg_data_o, 8'h00);
    chk("rst_rdata", cpu_rdata, 8'hFF);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_init_done", init_done, 1'b0);

    // Init sequence with two CPU commands queued behind it
    cen_en = 1'b1;
    @(posedge CLKSYS); #1; RESETBn = 1'b1;
    cpu_data(8'h07); cpu_cmd(8'h03);
    cpu_data(8'hAA); cpu_cmd(8'h02);
    n = 0;
    while (!init_done && n < 3000) begin @(negedge CLKSYS); n++; end
    chk("init_done_rise", init_done, 1'b1);
    chk("ops_at_init_done", q_op.size(), 8);
    wait_idle("init_idle");
    exp_rom(); exp_push(2'b11, 8'h07); exp_push(2'b10, 8'hAA);
    verify_ops("init");
    chk("init_ovf", ovf, 1'b0);

    // Read capture; simultaneous strobes keep the old latch value
    cpu_data(8'h0E); cpu_cmd(8'h03); cpu_cmd(8'h01);
    cpu_both(8'h02); cpu_cmd(8'h02);
    wait_idle("read_idle");
    chk("read_rdata", cpu_rdata, 8'h5A);
    exp_push(2'b11, 8'h0E); exp_push(2'b01, 8'h0E);
    exp_push(2'b10, 8'h0E); exp_push(2'b10, 8'h0E);
    verify_ops("read");

    // Ignored op codes
    cpu_cmd(8'h00);
    chk("ign00_busy", busy, 1'b0);
    cpu_cmd(8'h80);
    chk("ign80_busy", busy, 1'b0);
    repeat (60) @(negedge CLKSYS);
    chk("ign_ops", q_op.size(), 0);
    chk("ign_busy_late", busy, 1'b0);

    // Overflow with PSG_CEN stuck low: FSM parked in SETUP on the first init op
    cen_en = 1'b0;
    @(posedge CLKSYS); #1; RESETBn = 1'b0;
    repeat (2) @(posedge CLKSYS);
    #1; RESETBn = 1'b1;
    repeat (20) @(negedge CLKSYS);
    chk("stall_data", psg_data_o, 8'h07);
    chk("stall_bdir", psg_bdir, 1'b0);
    chk("stall_bc1", psg_bc1, 1'b0);
    cpu_data(8'h10); cpu_cmd(8'h03);
    cpu_data(8'h20); cpu_cmd(8'h02);
    cpu_data(8'h30); cpu_cmd(8'h02);
    chk("ovf_full3", fifo_full, 1'b0);
    cpu_cmd(8'h01);
    chk("ovf_full4", fifo_full, 1'b1);
    chk("ovf_before5", ovf, 1'b0);
    cpu_data(8'h40); cpu_cmd(8'h02);
    chk("ovf_after5", ovf, 1'b1);
    chk("ovf_full5", fifo_full, 1'b1);
    cen_en = 1'b1;
    wait_idle("ovf_idle");
    exp_rom();
    exp_push(2'b11, 8'h10); exp_push(2'b10, 8'h20);
    exp_push(2'b10, 8'h30); exp_push(2'b01, 8'h30);
    verify_ops("ovf");
    chk("ovf_sticky", ovf, 1'b1);
    chk("ovf_rdata", cpu_rdata, 8'h5A);
    chk("ovf_full_end", fifo_full, 1'b0);

    // Reset while ACTIVE, with one entry still queued
    cpu_data(8'h55); cpu_cmd(8'h02); cpu_cmd(8'h02);
    n = 0;
    while (!psg_bdir && n < 3000) begin @(negedge CLKSYS); n++; end
    chk("mid_active_seen", psg_bdir, 1'b1);
    RESETBn = 1'b0; cen_en = 1'b0;
    @(negedge CLKSYS);
    chk("mid_bdir", psg_bdir, 1'b0);
    chk("mid_bc1", psg_bc1, 1'b0);
    chk("mid_data", psg_data_o, 8'h00);
    chk("mid_full", fifo_full, 1'b0);
    chk("mid_rdata", cpu_rdata, 8'hFF);
    chk("mid_ovf", ovf, 1'b0);
    chk("mid_init_done", init_done, 1'b0);
    chk("mid_busy", busy, 1'b1);
    repeat (2) @(posedge CLKSYS);
    q_op.delete(); q_dat.delete(); q_hold.delete();
    cen_en = 1'b1;
    @(posedge CLKSYS); #1; RESETBn = 1'b1;
    wait_idle("rerun_idle");
    exp_rom();
    verify_ops("rerun");
    chk("rerun_init_done", init_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
